clk_tick_ctrl: RTL and testbench

- Programmable multi-channel tick scheduler.
- One free-running prescaler is shared by NCH channels. Each channel has its own runtime-programmable period and produces a one-cycle tick enable plus a square-wave toggle output.
- Replaces fixed-divider instances feeding timers, display scan and key debounce.
- Configured through a simple synchronous register write/read port driven by the AHB/APB bridge.

---
 rtl/clk_tick_ctrl.sv | 173 +++++++++++++++++
 tb/tb_clk_tick_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_tick_ctrl.sv
// clk_tick_ctrl: one free-running prescaler shared by NCH tick channels.
// Each channel has a runtime-programmable period (shadowed, applied at wrap)
// and produces a one-cycle tick pulse plus a square-wave toggle. A small
// synchronous register port sets enables, interrupt enables, sticky status
// flags and the per-channel periods.
module clk_tick_ctrl #(
    parameter int PRESCALE = 49,
    parameter int NCH      = 4,
    parameter int PW       = 16
) (
    input  logic           clk_in,
    input  logic           rstn,
    input  logic           wr_en,
    input  logic [3:0]     wr_addr,
    input  logic [31:0]    wr_data,
    input  logic [3:0]     rd_addr,
    output logic [31:0]    rd_data,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] toggle,
    output logic           irq
);

    localparam int             PCW  = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PCW-1:0] PMAX = PCW'(PRESCALE);

    logic [PCW-1:0] pcnt_r;
    logic           base_s;

    logic [NCH-1:0] en_r;
    logic [NCH-1:0] ie_r;
    logic [NCH-1:0] status_r;
    logic [NCH-1:0] tick_r;
    logic [NCH-1:0] toggle_r;
    logic [NCH-1:0] run_r;
    logic           irq_r;
    logic [PW-1:0]  cnt_r     [NCH];
    logic [PW-1:0]  per_act_r [NCH];
    logic [PW-1:0]  per_sh_r  [NCH];

    logic           ctrl_we_s;
    logic           stat_we_s;
    logic [NCH-1:0] per_we_s;
    logic [NCH-1:0] clr_s;
    logic [NCH-1:0] tick_nxt_s;
    logic [PW-1:0]  per_rd_s;
    logic           unused_wr_s;

    // Upper write-data bits beyond the defined fields are intentionally dropped.
    assign unused_wr_s = &{1'b0, wr_data};

    assign base_s = (pcnt_r == PMAX);
    assign tick   = tick_r;
    assign toggle = toggle_r;
    assign irq    = irq_r;

    // Free-running prescaler: counts 0..PRESCALE regardless of channel enables.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            pcnt_r <= {PCW{1'b0}};
        end else if (base_s) begin
            pcnt_r <= {PCW{1'b0}};
        end else begin
            pcnt_r <= pcnt_r + PCW'(1);
        end
    end

    // Write address decode and status write-1-to-clear mask.
    always_comb begin
        ctrl_we_s = wr_en && (wr_addr == 4'd0);
        stat_we_s = wr_en && (wr_addr == 4'd1);
        if (stat_we_s) begin
            clr_s = wr_data[NCH-1:0];
        end else begin
            clr_s = {NCH{1'b0}};
        end
        for (int i = 0; i < NCH; i++) begin
            per_we_s[i] = wr_en && (wr_addr == 4'(i + 2));
        end
    end

    // A channel wraps on a base tick once started and its count hits the active period.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            tick_nxt_s[i] = en_r[i] && base_s && run_r[i] && (cnt_r[i] == per_act_r[i]);
        end
    end

    // Register file: CTRL, sticky STATUS (set beats clear) and period shadows.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            en_r     <= {NCH{1'b0}};
            ie_r     <= {NCH{1'b0}};
            status_r <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                per_sh_r[i] <= {PW{1'b0}};
            end
        end else begin
            if (ctrl_we_s) begin
                en_r <= wr_data[NCH-1:0];
                ie_r <= wr_data[2*NCH-1:NCH];
            end
            status_r <= (status_r & ~clr_s) | tick_nxt_s;
            for (int i = 0; i < NCH; i++) begin
                if (per_we_s[i]) begin
                    per_sh_r[i] <= wr_data[PW-1:0];
                end
            end
        end
    end

    // Channel counters: the first base tick after enable only arms the channel,
    // later base ticks count up; the shadow period is loaded at each wrap.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            run_r    <= {NCH{1'b0}};
            toggle_r <= {NCH{1'b0}};
            tick_r   <= {NCH{1'b0}};
            for (int i = 0; i < NCH; i++) begin
                cnt_r[i]     <= {PW{1'b0}};
                per_act_r[i] <= {PW{1'b0}};
            end
        end else begin
            tick_r <= tick_nxt_s;
            for (int i = 0; i < NCH; i++) begin
                if (!en_r[i]) begin
                    run_r[i]     <= 1'b0;
                    toggle_r[i]  <= 1'b0;
                    cnt_r[i]     <= {PW{1'b0}};
                    per_act_r[i] <= per_sh_r[i];
                end else if (base_s) begin
                    if (!run_r[i]) begin
                        run_r[i] <= 1'b1;
                    end else if (cnt_r[i] == per_act_r[i]) begin
                        cnt_r[i]     <= {PW{1'b0}};
                        toggle_r[i]  <= ~toggle_r[i];
                        per_act_r[i] <= per_sh_r[i];
                    end else begin
                        cnt_r[i] <= cnt_r[i] + PW'(1);
                    end
                end
            end
        end
    end

    // Interrupt follows the registered STATUS masked by IE, one cycle behind.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |(status_r & ie_r);
        end
    end

    // Period readback mux: OR of address-qualified shadow registers.
    always_comb begin
        per_rd_s = {PW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            per_rd_s = per_rd_s | (per_sh_r[i] & {PW{rd_addr == 4'(i + 2)}});
        end
    end

    // Combinational read port; unmapped addresses return zero.
    always_comb begin
        if (rd_addr == 4'd0) begin
            rd_data = 32'({ie_r, en_r});
        end else if (rd_addr == 4'd1) begin
            rd_data = 32'(status_r);
        end else begin
            rd_data = 32'(per_rd_s);
        end
    end

endmodule

// File: tb/tb_clk_tick_ctrl.sv
// Self-checking bench for clk_tick_ctrl (PRESCALE=3, NCH=4, PW=16).
// A countdown-style reference model predicts every output each cycle; table
// vectors and directed sequences add explicit expectations.
module tb_clk_tick_ctrl;

    localparam int P = 3;

    logic        clk_in = 1'b0;
    logic        rstn   = 1'b0;
    logic        wr_en  = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [31:0] wr_data = 32'd0;
    logic [3:0]  rd_addr = 4'd0;
    logic [31:0] rd_data;
    logic [3:0]  tick;
    logic [3:0]  toggle;
    logic        irq;

    clk_tick_ctrl #(.PRESCALE(P), .NCH(4), .PW(16)) dut (
        .clk_in(clk_in), .rstn(rstn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .tick(tick), .toggle(toggle), .irq(irq)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    int          edge_idx;
    int          last_edge;
    logic [3:0]  m_en, m_ie, m_st, m_tick, m_tog;
    logic        m_irq;
    logic [15:0] m_sh [4];
    int          m_act [4];
    int          m_left [4];   // base ticks until next tick; -1 = not yet armed

    typedef struct {
        logic        we;
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  ra;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        edge_idx = 0;
        m_en = 4'd0; m_ie = 4'd0; m_st = 4'd0; m_tick = 4'd0; m_tog = 4'd0; m_irq = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_sh[i] = 16'd0; m_act[i] = 0; m_left[i] = -1;
        end
    endtask

    task automatic model_edge(input logic we, input logic [3:0] a, input logic [31:0] d);
        bit base;
        logic [3:0] nt;
        logic [3:0] clr;
        base  = (edge_idx % (P + 1)) == P;
        nt    = 4'd0;
        m_irq = |(m_st & m_ie);
        for (int i = 0; i < 4; i++) begin
            if (!m_en[i]) begin
                m_left[i] = -1;
                m_act[i]  = int'(m_sh[i]);
                m_tog[i]  = 1'b0;
            end else if (base) begin
                if (m_left[i] < 0) begin
                    m_left[i] = m_act[i] + 1;
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        nt[i]     = 1'b1;
                        m_tog[i]  = ~m_tog[i];
                        m_act[i]  = int'(m_sh[i]);
                        m_left[i] = m_act[i] + 1;
                    end
                end
            end
        end
        m_tick = nt;
        clr  = (we && a == 4'd1) ? d[3:0] : 4'd0;
        m_st = (m_st & ~clr) | nt;
        if (we) begin
            if (a == 4'd0) begin
                m_en = d[3:0];
                m_ie = d[7:4];
            end else if (a >= 4'd2 && a <= 4'd5) begin
                m_sh[int'(a) - 2] = d[15:0];
            end
        end
        edge_idx++;
    endtask

    function automatic logic [31:0] model_rd(input logic [3:0] a);
        if (a == 4'd0) return {24'd0, m_ie, m_en};
        if (a == 4'd1) return {28'd0, m_st};
        if (a >= 4'd2 && a <= 4'd5) return {16'd0, m_sh[int'(a) - 2]};
        return 32'd0;
    endfunction

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic cycle(input logic we, input logic [3:0] a, input logic [31:0] d, input logic [3:0] ra);
        wr_en = we; wr_addr = a; wr_data = d; rd_addr = ra;
        @(posedge clk_in);
        model_edge(we, a, d);
        last_edge = edge_idx - 1;
        @(negedge clk_in);
        chk("tick",    32'(tick),   32'(m_tick));
        chk("toggle",  32'(toggle), 32'(m_tog));
        chk("irq",     32'(irq),    32'(m_irq));
        chk("rd_data", rd_data,     model_rd(ra));
        wr_en = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 32'd0, 4'($urandom_range(0, 9)));
    endtask

    // Wait (bounded) for a tick on channel ch; returns the edge index it fired on.
    task automatic wait_tick(input int ch, input int bound, output int e);
        bit found;
        found = 1'b0;
        e = -1;
        for (int n = 0; n < bound && !found; n++) begin
            idle();
            if (tick[ch]) begin
                found = 1'b1;
                e = last_edge;
            end
        end
        if (!found) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_tick%0d: got no tick expected one within %0d cycles", ch, bound);
        end
    endtask

    initial begin
        int t0, t1, t2, t3, t4, e_en, kb, cnt;
        bit hit;
        logic [3:0] ra;
        logic [31:0] d;

        tbl[0]  = '{1'b0, 4'd0, 32'd0,         4'd0, 32'd0};
        tbl[1]  = '{1'b0, 4'd0, 32'd0,         4'd1, 32'd0};
        tbl[2]  = '{1'b0, 4'd0, 32'd0,         4'd2, 32'd0};
        tbl[3]  = '{1'b0, 4'd0, 32'd0,         4'd3, 32'd0};
        tbl[4]  = '{1'b0, 4'd0, 32'd0,         4'd4, 32'd0};
        tbl[5]  = '{1'b0, 4'd0, 32'd0,         4'd5, 32'd0};
        tbl[6]  = '{1'b0, 4'd0, 32'd0,         4'd9, 32'd0};
        tbl[7]  = '{1'b1, 4'd7, 32'hFFFF_FFFF, 4'd7, 32'd0};
        tbl[8]  = '{1'b0, 4'd0, 32'd0,         4'd0, 32'd0};
        tbl[9]  = '{1'b0, 4'd0, 32'd0,         4'd2, 32'd0};
        tbl[10] = '{1'b1, 4'd5, 32'hABCD_1234, 4'd5, 32'h0000_1234};
        tbl[11] = '{1'b1, 4'd0, 32'hFFFF_FFF0, 4'd0, 32'h0000_00F0};
        tbl[12] = '{1'b1, 4'd1, 32'hFFFF_FFFF, 4'd1, 32'd0};
        tbl[13] = '{1'b1, 4'd0, 32'd0,         4'd0, 32'd0};

        model_reset();
        @(negedge clk_in);
        @(negedge clk_in);
        rstn = 1'b1;

        // Channel 0, period 4: ticks every 20 cycles, status set, no irq.
        cycle(1'b1, 4'd2, 32'd4, 4'd2);
        chk("per0_rd", rd_data, 32'd4);
        cycle(1'b1, 4'd0, 32'h01, 4'd0);
        wait_tick(0, 60, t0);
        wait_tick(0, 60, t1);
        wait_tick(0, 60, t2);
        chk("ch0_spacing_a", 32'(t1 - t0), 32'd20);
        chk("ch0_spacing_b", 32'(t2 - t1), 32'd20);
        cycle(1'b0, 4'd0, 32'd0, 4'd1);
        chk("status_ch0", rd_data, 32'd1);
        chk("irq_masked", 32'(irq), 32'd0);
        cycle(1'b1, 4'd0, 32'h11, 4'd0);
        idle();
        chk("irq_enabled", 32'(irq), 32'd1);

        // Period change mid-interval applies only after the current wrap.
        for (int k = 0; k < 3; k++) idle();
        cycle(1'b1, 4'd2, 32'd9, 4'd2);
        chk("per0_rd9", rd_data, 32'd9);
        wait_tick(0, 60, t3);
        wait_tick(0, 60, t4);
        chk("ch0_old_interval", 32'(t3 - t2), 32'd20);
        chk("ch0_new_interval", 32'(t4 - t3), 32'd40);

        // Status clear coinciding with a tick: set wins.
        hit = 1'b0;
        for (int n = 0; n < 80 && !hit; n++) begin
            if (m_en[0] && (edge_idx % (P + 1)) == P && m_left[0] == 1) hit = 1'b1;
            else idle();
        end
        chk("tick_predicted", 32'(hit), 32'd1);
        cycle(1'b1, 4'd1, 32'h1, 4'd1);
        chk("clr_vs_tick_tick", 32'(tick[0]), 32'd1);
        chk("clr_vs_tick_status", rd_data & 32'h1, 32'd1);
        idle();
        cycle(1'b1, 4'd1, 32'h1, 4'd1);
        chk("status_cleared", rd_data, 32'd0);
        chk("irq_lag", 32'(irq), 32'd1);
        idle();
        chk("irq_deassert", 32'(irq), 32'd0);

        // Channels 1 and 2 with periods 0 and 2; disable/re-enable of ch2.
        cycle(1'b1, 4'd0, 32'h0, 4'd0);
        cycle(1'b1, 4'd3, 32'd0, 4'd3);
        cycle(1'b1, 4'd4, 32'd2, 4'd4);
        cycle(1'b1, 4'd0, 32'h6, 4'd0);
        wait_tick(1, 20, t0);
        wait_tick(1, 20, t1);
        chk("ch1_spacing", 32'(t1 - t0), 32'd4);
        wait_tick(2, 40, t0);
        wait_tick(2, 40, t1);
        chk("ch2_spacing", 32'(t1 - t0), 32'd12);
        for (int k = 0; k < 5; k++) idle();
        cycle(1'b1, 4'd0, 32'h2, 4'd0);
        idle();
        chk("ch2_toggle_off", 32'(toggle[2]), 32'd0);
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            idle();
            if (tick[2]) cnt++;
        end
        chk("ch2_no_tick", 32'(cnt), 32'd0);
        cycle(1'b1, 4'd4, 32'd5, 4'd4);
        cycle(1'b1, 4'd0, 32'h6, 4'd0);
        e_en = last_edge;
        kb = e_en + 1;
        while ((kb % (P + 1)) != P) kb++;
        wait_tick(2, 60, t2);
        chk("ch2_first_tick", 32'(t2 - kb), 32'd24);

        // Randomized register traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            ra = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) begin
                d = $urandom;
                wr_addr = 4'($urandom_range(0, 9));
                if (wr_addr >= 4'd2 && wr_addr <= 4'd5) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 7));
                cycle(1'b1, wr_addr, d, ra);
            end else begin
                cycle(1'b0, 4'd0, 32'd0, ra);
            end
        end

        // Asynchronous reset mid-run clears outputs immediately.
        cycle(1'b1, 4'd0, 32'hFF, 4'd0);
        for (int k = 0; k < 25; k++) idle();
        rd_addr = 4'd0;
        #2 rstn = 1'b0;
        #1;
        chk("rst_tick",   32'(tick),   32'd0);
        chk("rst_toggle", 32'(toggle), 32'd0);
        chk("rst_irq",    32'(irq),    32'd0);
        chk("rst_ctrl",   rd_data,     32'd0);
        @(posedge clk_in);
        @(negedge clk_in);
        rstn = 1'b1;
        model_reset();

        // Register map vectors: reset readback, unmapped address, field masking.
        for (int k = 0; k < 14; k++) begin
            cycle(tbl[k].we, tbl[k].a, tbl[k].d, tbl[k].ra);
            chk($sformatf("tbl%0d", k), rd_data, tbl[k].exp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
